pos_cart_cmd_arbiter: RTL and testbench
=======================================

Name: pos_cart_cmd_arbiter

Overview:
- Shares the single cart-update port of the POS cart datapath between two requesters: requester 0 (barcode scanner) and requester 1 (keypad).
- Arbitrates round-robin and validates each command locally.
- Issues one add/remove command at a time to the cart, waits for its completion or a timeout, then returns a per-requester response code.
- Sits between the input front-ends and the cart datapath; a checkout lock input freezes cart updates.

Parameters:
- ID_W, 16, item barcode width.
- AMT_W, 4, item amount width.
- MAX_AMT, 4, largest amount accepted for a single add.
- TIMEOUT_CYC, 15, cycles allowed from command issue to cart_done before a timeout response (max 255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  2  request pending, one bit per requester.
- req_op  in  2  per-requester op: 0 = add, 1 = remove.
- req_id  in  2*ID_W  per-requester barcode; requester 0 in the low slice.
- req_amt  in  2*AMT_W  per-requester amount; ignored for remove.
- req_ready  out  2  one-cycle acceptance pulse.
- rsp_valid  out  2  one-cycle response pulse.
- rsp_code  out  2  response code, valid with rsp_valid: 00 ok, 01 rejected, 10 timeout, 11 locked.
- cart_cmd_valid  out  1  command to cart valid.
- cart_cmd_ready  in  1  cart accepts command.
- cart_cmd_op  out  1  latched op.
- cart_cmd_id  out  ID_W  latched barcode.
- cart_cmd_amt  out  AMT_W  latched amount; driven 0 for remove.
- cart_done  in  1  cart finished the command (single-cycle pulse).
- cart_success  in  1  cart result, qualified by cart_done.
- lock  in  1  checkout in progress; no cart updates allowed.
- busy  out  1  high whenever the FSM is not in IDLE.
- grant_idx  out  1  requester currently owning the transaction.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0 (requester 0 preferred), timeout counter 0.
- Reset asserted mid-transaction aborts it silently: no response is issued, cart_cmd_valid drops immediately.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant g = pointer when req_valid[pointer] is set, else the other requester.
  - Pulse req_ready[g] for one cycle and latch op, id and amt; set grant_idx = g.
  - If lock=1, or the command fails local validation, go to RESP with code 11 (locked) or 01 (rejected) respectively; the cart is not touched.
  - Lock takes precedence over validation.
  - Otherwise go to ISSUE and clear the timeout counter.
- Local validation rejects:
  - id == 0;
  - add with amt == 0;
  - add with amt > MAX_AMT.
- ISSUE:
  - cart_cmd_valid=1 with fields held stable until cart_cmd_ready=1; then go to WAIT.
  - The counter increments each cycle in ISSUE and WAIT.
- WAIT:
  - On cart_done, go to RESP with code 00 if cart_success else 01.
  - If the counter reaches TIMEOUT_CYC without cart_done, go to RESP with code 10; cart_cmd_valid is deasserted even if the cart never accepted.
  - cart_done in the same cycle the counter hits the limit: done wins.
  - The timeout check also applies in ISSUE.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle with rsp_code; set pointer = ~g; return to IDLE.
- Latency:
  - Accept in cycle N, cart_cmd_valid at N+1.
  - With cart_cmd_ready at N+1 and cart_done at N+2, rsp_valid is at N+3.
  - A locked or rejected request gets rsp_valid at N+1.
- Single outstanding transaction: req_ready is never asserted outside IDLE, and no back-to-back grant happens in the RESP cycle.
- cart_done or cart_cmd_ready outside ISSUE/WAIT is ignored, including a late done after a timeout.
- lock changing during ISSUE/WAIT does not affect the in-flight command; lock is sampled only at grant.
- Requesters hold req_valid and fields until req_ready. Deassertion before acceptance is permitted; the request is simply not granted.

Decomposition:
- Shared package pos_pkg holds:
  - op encodings (OP_ADD, OP_REMOVE);
  - rsp_code constants (RSP_OK, RSP_REJ, RSP_TIMEOUT, RSP_LOCKED);
  - the FSM state typedef;
  - ID_W, AMT_W and MAX_AMT defaults, shared with the cart datapath.
- One natural sub-module, pos_rr_arb2: a 2-way round-robin grant with pointer update on a completion strobe.
- Validation, timeout counter and FSM stay in the top module.

Test Plan:
- Single add, no contention:
  - Stimulus: req 0 add id=3124 amt=2; cart ready immediately, done with success=1 one cycle later.
  - Response: cart_cmd_id=3124, cart_cmd_amt=2; rsp_valid[0] 3 cycles after accept, code 00.
- Simultaneous requests:
  - Stimulus: both requesters valid continuously for 4 transactions.
  - Response: grants alternate 0,1,0,1; each rsp_valid goes only to the granted requester.
- Local rejects:
  - Stimulus: add amt=5; add amt=0; remove id=0.
  - Response: each gives code 01 one cycle after accept with cart_cmd_valid never asserted; remove with amt=9 and a valid id is issued with cart_cmd_amt=0.
- Lock:
  - Stimulus: lock=1, req 1 add id=4444 amt=1.
  - Response: code 11 with no cart command. Raising lock during WAIT of an earlier command still completes it with code 00.
- Timeout:
  - Stimulus: cart_done withheld.
  - Response: code 10 exactly TIMEOUT_CYC cycles after entering ISSUE. A late cart_done produces no response; cart_done on the limit cycle gives code 00/01 instead.
- Reset mid-WAIT:
  - Stimulus: assert rst asynchronously.
  - Response: all outputs 0 immediately, no rsp_valid; after release, the next request to requester 0 is granted first.

Source files
------------

// File: rtl/pos_pkg.sv
// Shared POS cart definitions: op/response encodings, arbiter FSM states and
// the item field widths used by both the arbiter and the cart datapath.
package pos_pkg;

  localparam int POS_ID_W    = 16;
  localparam int POS_AMT_W   = 4;
  localparam int POS_MAX_AMT = 4;

  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_REMOVE = 1'b1;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_REJ     = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;
  localparam logic [1:0] RSP_LOCKED  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/pos_cart_cmd_arbiter_if.sv
// Requester, cart and status signals of the cart command arbiter.
// master = arbiter side, slave = requesters/cart/observer side.
interface pos_cart_cmd_arbiter_if
  import pos_pkg::*;
#(
  parameter int ID_W  = POS_ID_W,
  parameter int AMT_W = POS_AMT_W
);
  // Handshakes: a requester holds req_valid and its fields until req_ready
  // pulses; cart_cmd_* is held stable while cart_cmd_valid && !cart_cmd_ready.
  logic [1:0]         req_valid;
  logic [1:0]         req_op;
  logic [2*ID_W-1:0]  req_id;
  logic [2*AMT_W-1:0] req_amt;
  logic [1:0]         req_ready;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_code;
  logic               cart_cmd_valid;
  logic               cart_cmd_ready;
  logic               cart_cmd_op;
  logic [ID_W-1:0]    cart_cmd_id;
  logic [AMT_W-1:0]   cart_cmd_amt;
  logic               cart_done;
  logic               cart_success;
  logic               lock;
  logic               busy;
  logic               grant_idx;
  arb_state_e         dbg_state;

  modport master (
    input  req_valid, req_op, req_id, req_amt, cart_cmd_ready, cart_done,
           cart_success, lock,
    output req_ready, rsp_valid, rsp_code, cart_cmd_valid, cart_cmd_op,
           cart_cmd_id, cart_cmd_amt, busy, grant_idx, dbg_state
  );

  modport slave (
    output req_valid, req_op, req_id, req_amt, cart_cmd_ready, cart_done,
           cart_success, lock,
    input  req_ready, rsp_valid, rsp_code, cart_cmd_valid, cart_cmd_op,
           cart_cmd_id, cart_cmd_amt, busy, grant_idx, dbg_state
  );

endinterface

// File: rtl/pos_rr_arb2.sv
// Two-way round-robin grant; the preferred requester flips to the other one
// whenever a transaction completes.
module pos_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_idx,
  output logic       gnt_idx,
  output logic       gnt_any
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (done) ptr_d = ~done_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  assign gnt_any = |req;
  assign gnt_idx = req[ptr_q] ? ptr_q : ~ptr_q;

endmodule

// File: rtl/pos_cart_cmd_arbiter.sv
// Shares the cart-update port between scanner and keypad: one validated
// command in flight at a time, bounded by a timeout, answered per requester.
module pos_cart_cmd_arbiter
  import pos_pkg::*;
#(
  parameter int ID_W        = POS_ID_W,
  parameter int AMT_W       = POS_AMT_W,
  parameter int MAX_AMT     = POS_MAX_AMT,
  parameter int TIMEOUT_CYC = 15
) (
  input logic clk,
  input logic rst,
  pos_cart_cmd_arbiter_if.master bus
);

  localparam logic [AMT_W-1:0] MAX_AMT_V = AMT_W'(MAX_AMT);
  localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT_CYC - 1);

  arb_state_e       state_q, state_d;
  logic             op_q, op_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             gnt_q, gnt_d;
  logic [1:0]       code_q, code_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             arb_gnt, arb_any, rsp_fire;
  logic             sel_op, sel_bad;
  logic [ID_W-1:0]  sel_id;
  logic [AMT_W-1:0] sel_amt;

  assign rsp_fire = (state_q == ST_RESP);

  pos_rr_arb2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.req_valid),
    .done     (rsp_fire),
    .done_idx (gnt_q),
    .gnt_idx  (arb_gnt),
    .gnt_any  (arb_any)
  );

  always_comb begin
    sel_op  = bus.req_op[arb_gnt];
    sel_id  = arb_gnt ? bus.req_id[2*ID_W-1:ID_W] : bus.req_id[ID_W-1:0];
    sel_amt = arb_gnt ? bus.req_amt[2*AMT_W-1:AMT_W] : bus.req_amt[AMT_W-1:0];
    sel_bad = (sel_id == '0) ||
              ((sel_op == OP_ADD) && ((sel_amt == '0) || (sel_amt > MAX_AMT_V)));
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    amt_d   = amt_q;
    gnt_d   = gnt_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d = arb_gnt;
          op_d  = sel_op;
          id_d  = sel_id;
          amt_d = (sel_op == OP_REMOVE) ? '0 : sel_amt;
          cnt_d = '0;
          // lock is only looked at here; it outranks validation
          if (bus.lock) begin
            code_d  = RSP_LOCKED;
            state_d = ST_RESP;
          end else if (sel_bad) begin
            code_d  = RSP_REJ;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == TMO_LAST) begin
          code_d  = RSP_TIMEOUT;
          state_d = ST_RESP;
        end else if (bus.cart_cmd_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // a done on the limit cycle still reports the cart's own result
        if (bus.cart_done) begin
          code_d  = bus.cart_success ? RSP_OK : RSP_REJ;
          state_d = ST_RESP;
        end else if (cnt_q == TMO_LAST) begin
          code_d  = RSP_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 1'b0;
      id_q    <= '0;
      amt_q   <= '0;
      gnt_q   <= 1'b0;
      code_q  <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      amt_q   <= amt_d;
      gnt_q   <= gnt_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // req_ready is combinational from req_valid, so it is masked during reset
  assign bus.req_ready = (!rst && state_q == ST_IDLE && arb_any) ?
                         (arb_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid      = rsp_fire ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_code       = rsp_fire ? code_q : 2'b00;
  assign bus.cart_cmd_valid = (state_q == ST_ISSUE);
  assign bus.cart_cmd_op    = op_q;
  assign bus.cart_cmd_id    = id_q;
  assign bus.cart_cmd_amt   = amt_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.grant_idx      = gnt_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_pos_cart_cmd_arbiter.sv
// Bench for pos_cart_cmd_arbiter: directed scenarios plus randomized
// transactions predicted per transaction from the arbitration rules.
module tb_pos_cart_cmd_arbiter;
  import pos_pkg::*;

  localparam int T       = 15;
  localparam int MAX_AMT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_e;
  bit   pref = 1'b0;

  pos_cart_cmd_arbiter_if #(.ID_W(16), .AMT_W(4)) bus ();

  pos_cart_cmd_arbiter #(
    .ID_W(16), .AMT_W(4), .MAX_AMT(MAX_AMT), .TIMEOUT_CYC(T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every response pulse must match the next expected {requester, code}
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {bus.rsp_valid, bus.rsp_code}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_code", {bus.rsp_valid[1], bus.rsp_code}, mon_e);
      end
    end
  end

  // driver: present a request, play the cart, check timing cycle by cycle
  task automatic do_txn(input logic [1:0] v, input logic [1:0] op, input logic [31:0] id,
                        input logic [7:0] amt, input bit lk, input bit lk_mid,
                        input int rdy_k, input int done_k, input bit succ, input int abort_k);
    bit g, bad, acc;
    logic e_op;
    logic [15:0] e_id;
    logic [3:0] e_amt;
    logic [1:0] code, oh;
    int issue_end, k_resp;
    g     = v[pref] ? pref : ~pref;
    oh    = g ? 2'b10 : 2'b01;
    e_op  = op[g];
    e_id  = g ? id[31:16] : id[15:0];
    e_amt = g ? amt[7:4] : amt[3:0];
    bad   = (e_id == 0) || (e_op == 1'b0 && (e_amt == 0 || e_amt > MAX_AMT));
    acc   = (rdy_k >= 0 && rdy_k <= T - 2);
    if (lk || bad) begin
      issue_end = -1;
      k_resp    = 0;
      code      = lk ? 2'b11 : 2'b01;
    end else begin
      issue_end = acc ? rdy_k : T - 1;
      if (acc && done_k > rdy_k && done_k <= T - 1) begin
        k_resp = done_k + 1;
        code   = succ ? 2'b00 : 2'b01;
      end else begin
        k_resp = T;
        code   = 2'b10;
      end
    end
    if (abort_k < 0) exp_q.push_back({g, code});

    @(negedge clk);
    bus.req_valid      = v;
    bus.req_op         = op;
    bus.req_id         = id;
    bus.req_amt        = amt;
    bus.lock           = lk;
    bus.cart_cmd_ready = 1'b0;
    bus.cart_done      = 1'b0;
    #1;
    chk("req_ready_accept", bus.req_ready, oh);
    chk("busy_accept", bus.busy, 0);

    for (int k = 0; k <= k_resp + 2; k++) begin
      @(negedge clk);
      if (k == 0) bus.req_valid[g] = 1'b0;
      if (k == k_resp + 1) begin
        bus.req_valid = 2'b00;
        bus.lock      = 1'b0;
      end
      bus.cart_cmd_ready = (k == rdy_k);
      bus.cart_done      = (k == done_k);
      bus.cart_success   = succ;
      if (lk_mid && k == issue_end + 1) bus.lock = 1'b1;
      if (k == abort_k) begin
        bus.req_valid = 2'b11;
        #2 rst = 1'b1;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_code", bus.rsp_code, 0);
        chk("rst_cmd_valid", bus.cart_cmd_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant_idx", bus.grant_idx, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_cmd_id", bus.cart_cmd_id, 0);
        @(negedge clk);
        rst                = 1'b0;
        bus.req_valid      = 2'b00;
        bus.cart_done      = 1'b0;
        bus.cart_cmd_ready = 1'b0;
        bus.lock           = 1'b0;
        pref               = 1'b0;
        return;
      end
      #1;
      chk("cmd_valid", bus.cart_cmd_valid, (k <= issue_end));
      chk("rsp_valid", bus.rsp_valid, (k == k_resp) ? oh : 2'b00);
      chk("busy", bus.busy, (k <= k_resp));
      chk("req_ready_hold", bus.req_ready, 0);
      if (k == 0) begin
        chk("grant_idx", bus.grant_idx, g);
        if (issue_end >= 0) begin
          chk("cmd_op", bus.cart_cmd_op, e_op);
          chk("cmd_id", bus.cart_cmd_id, e_id);
          chk("cmd_amt", bus.cart_cmd_amt, e_op ? 4'd0 : e_amt);
        end
      end
    end
    bus.cart_done      = 1'b0;
    bus.cart_cmd_ready = 1'b0;
    pref = ~g;
  endtask

  initial begin
    logic [1:0] v, op;
    logic [31:0] rid;
    logic [7:0] ramt;
    int r, rdy, dn;
    bus.req_valid      = 2'b11;
    bus.req_op         = 2'b00;
    bus.req_id         = 32'h0001_0001;
    bus.req_amt        = 8'h11;
    bus.cart_cmd_ready = 1'b0;
    bus.cart_done      = 1'b0;
    bus.cart_success   = 1'b0;
    bus.lock           = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_cmd_valid", bus.cart_cmd_valid, 0);
    chk("reset_busy", bus.busy, 0);
    bus.req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_grant_idx", bus.grant_idx, 0);
    chk("idle_cmd_id", bus.cart_cmd_id, 0);
    chk("idle_rsp_code", bus.rsp_code, 0);

    // contention: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++)
      do_txn(2'b11, 2'b00, {16'd7, 16'd8}, {4'd1, 4'd3}, 0, 0, 0, 2, 1, -1);
    // single add, response three cycles after accept
    do_txn(2'b01, 2'b00, {16'd0, 16'd3124}, {4'd0, 4'd2}, 0, 0, 0, 1, 1, -1);
    // local rejects, then a remove with a stray amount
    do_txn(2'b01, 2'b00, {16'd0, 16'd55}, {4'd0, 4'd5}, 0, 0, 0, 1, 1, -1);
    do_txn(2'b01, 2'b00, {16'd0, 16'd55}, {4'd0, 4'd0}, 0, 0, 0, 1, 1, -1);
    do_txn(2'b01, 2'b01, {16'd0, 16'd0}, {4'd0, 4'd1}, 0, 0, 0, 1, 1, -1);
    do_txn(2'b01, 2'b01, {16'd0, 16'd77}, {4'd0, 4'd9}, 0, 0, 1, 3, 1, -1);
    // lock at grant, then lock raised mid-flight
    do_txn(2'b10, 2'b00, {16'd4444, 16'd0}, {4'd1, 4'd0}, 1, 0, 0, 1, 1, -1);
    do_txn(2'b10, 2'b00, {16'd4444, 16'd0}, {4'd1, 4'd0}, 0, 1, 0, 3, 1, -1);
    // timeouts: no done, late done, done on limit cycle, never accepted
    do_txn(2'b01, 2'b00, {16'd0, 16'd9}, {4'd0, 4'd1}, 0, 0, 0, -1, 1, -1);
    do_txn(2'b01, 2'b00, {16'd0, 16'd9}, {4'd0, 4'd1}, 0, 0, 0, T + 1, 1, -1);
    do_txn(2'b01, 2'b00, {16'd0, 16'd9}, {4'd0, 4'd1}, 0, 0, 0, T - 1, 0, -1);
    do_txn(2'b01, 2'b00, {16'd0, 16'd9}, {4'd0, 4'd1}, 0, 0, -1, -1, 1, -1);
    // reset mid-WAIT, then requester 0 must win a tie
    do_txn(2'b01, 2'b00, {16'd0, 16'd5}, {4'd0, 4'd1}, 0, 0, 0, 1, 1, -1);
    do_txn(2'b01, 2'b00, {16'd0, 16'd5}, {4'd0, 4'd1}, 0, 0, 0, -1, 1, 3);
    do_txn(2'b11, 2'b00, {16'd6, 16'd5}, {4'd1, 4'd1}, 0, 0, 0, 1, 1, -1);

    for (int i = 0; i < 40; i++) begin
      v  = 2'($urandom_range(1, 3));
      op = 2'($urandom_range(0, 3));
      for (int q = 0; q < 2; q++) begin
        rid[q*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        ramt[q*4 +: 4]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(1, 4));
      end
      r = $urandom_range(0, 9);
      rdy = (r < 7) ? r % 4 : ((r == 7) ? -1 : T - 2);
      if (rdy < 0) begin
        dn = ($urandom_range(0, 1) == 0) ? -1 : T + 1;
      end else begin
        r  = $urandom_range(0, 7);
        dn = (r < 5) ? rdy + 1 + r : ((r == 5) ? -1 : ((r == 6) ? T - 1 : T + 1));
      end
      do_txn(v, op, rid, ramt, ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
             rdy, dn, 1'($urandom_range(0, 1)), -1);
    end

    repeat (2) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
